pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
// Sequences one fabric PLL (50 MHz refclk in, single outclk) from power-up to a clean downstream reset release.
// Pulses the PLL reset, waits for lock with a timeout, and requires lock to hold for a stability window.
// Only then does it deassert the reset of logic clocked by the PLL output.
// Lives in the refclk domain next to the PLL wrapper; retries failed locks and reports status to the HPS via the CSR block.
// PARAMETERS
// RST_PULSE_CYCLES     16     clk cycles pll_rst is held high per attempt (>=1)
// LOCK_TIMEOUT_CYCLES  50000  max cycles in WAIT_LOCK before attempt fails (1 ms @ 50 MHz)
// LOCK_STABLE_CYCLES   1024   consecutive synced-lock cycles required before release
// MAX_RETRIES          4      failed attempts (timeouts) before FAULT (>=1)
// CNT_W                20     width of shared cycle counter; must hold max of the three cycle params
// PORTS
// clk           in   1  free-running 50 MHz reference clock (same net as PLL refclk)
// reset_n       in   1  synchronous, active-low reset
// pll_locked    in   1  PLL locked output, asynchronous to clk
// relock_req    in   1  single-cycle pulse: force a full re-lock sequence
// pll_rst       out  1  to PLL rst, active high, registered
// out_reset_n   out  1  active-low reset for PLL-clocked logic, registered
// fault         out  1  high in FAULT state
// state         out  3  0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT
// relock_count  out  8  number of re-lock sequences started after first RUN; saturates at 255
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): state=RESET_PLL, cnt=0, attempts=0, pll_rst=1, out_reset_n=0, fault=0, relock_count=0, sync flops=0.
// - pll_locked passes a 2-flop synchronizer -> lock_s; all decisions use lock_s (2-cycle latency).
// - RESET_PLL: pll_rst=1; cnt counts; after RST_PULSE_CYCLES cycles -> WAIT_LOCK, cnt=0. pll_rst goes low the cycle state becomes WAIT_LOCK.
// - WAIT_LOCK: lock_s=1 -> STABILIZE, cnt=0.
// - WAIT_LOCK timeout: cnt reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> attempts+1.
//   If new attempts==MAX_RETRIES -> FAULT, else -> RESET_PLL.
// - STABILIZE: lock_s=0 -> WAIT_LOCK, cnt=0; timeout budget restarts, attempts unchanged.
//   LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> RUN, attempts=0.
// - RUN: out_reset_n=1 (rises the first cycle state==RUN); pll_rst=0. Lock-loss handling per CONFIGURATION.
// - FAULT: pll_rst=0, out_reset_n=0, fault=1; held until relock_req or reset_n.
// - out_reset_n=0 in every state except RUN; it drops on the same edge that leaves RUN.
// - relock_req=1 in any state -> RESET_PLL next cycle, cnt=0, attempts=0, fault cleared.
//   relock_count+1 (saturating) if a RUN has been reached since reset_n.
// - Simultaneous relock_req and lock loss in RUN: one transition to RESET_PLL; relock_count increments once.
// - relock_req while already in RESET_PLL restarts the pulse (cnt=0).
// - Counter never wraps: cleared on every state change; compare is exact equality.
// CONFIGURATION
// PLL_SUP_AUTO_RELOCK_EN defined:
//   RUN with lock_s=0 -> RESET_PLL next cycle, attempts=0, relock_count+1 (saturating).
// PLL_SUP_AUTO_RELOCK_EN undefined:
//   RUN with lock_s=0 -> FAULT next cycle, relock_count unchanged; only relock_req/reset_n recovers.
// TESTING (params: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
// 1 Bring-up: release reset_n, pll_locked=1 from cycle 10 -> pll_rst high 4 cycles; out_reset_n rises ~cycle 20 (2 sync + 8 stable); state=3; fault=0.
// 2 Timeout/fault: pll_locked=0 forever -> two 4-cycle pll_rst pulses 100 cycles apart; then state=4, fault=1, out_reset_n=0, pll_rst=0.
// 3 Glitch in STABILIZE: lock high 5 cycles, low 1, high -> returns WAIT_LOCK; out_reset_n only after 8 uninterrupted cycles; attempts unchanged.
// 4 Lock loss in RUN: drop pll_locked 1 cycle -> AUTO_RELOCK_EN: out_reset_n low 2 cycles later, new pll_rst pulse, relock_count=1. Without macro: state=4, fault=1, relock_count=0.
// 5 relock_req from FAULT and from RUN (simultaneous with lock loss) -> RESET_PLL next cycle, fault=0, relock_count increments by exactly 1 (RUN case only).
// 6 Mid-sequence reset: assert reset_n=0 in STABILIZE -> next edge all outputs at reset values; relock_count=0; saturation: 256 relocks -> relock_count=255.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Sequences one fabric PLL: reset pulse, lock wait with timeout and retries, stability window, then downstream reset release.
// Latency: pll_locked is seen 2 cycles late via a 2-flop synchronizer; all outputs are registered and follow state on the same edge.
// No backpressure; relock_req is honoured in any state. Optional PLL_SUP_AUTO_RELOCK_EN: lock loss in RUN relocks instead of faulting.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned CNT_W               = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       out_reset_n,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] relock_count
);

    localparam int unsigned ATT_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_MAX      = ATT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [ATT_W-1:0]   attempts_q;
    logic [ATT_W-1:0]   attempts_d;
    logic [7:0]         relock_count_q;
    logic [7:0]         relock_count_d;
    logic               relock_inc;
    logic               run_seen_q;
    logic               sync_meta_q;
    logic               lock_s;
    logic               pll_rst_q;
    logic               out_reset_n_q;
    logic               fault_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta_q <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            sync_meta_q <= pll_locked;
            lock_s      <= sync_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        attempts_d = attempts_q;
        relock_inc = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (lock_s) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempts_d = attempts_q + 1'b1;
                    state_d    = (attempts_d == ATT_MAX) ? S_FAULT : S_RESET_PLL;
                end
            end
            S_STABILIZE: begin
                cnt_d = cnt_q + 1'b1;
                // A single dropout sends us back to wait, keeping the retry tally.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d    = S_RUN;
                    attempts_d = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                    state_d    = S_RESET_PLL;
                    attempts_d = '0;
                    relock_inc = 1'b1;
`else
                    state_d    = S_FAULT;
`endif
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // Operator relock overrides everything, including a coincident lock loss.
        if (relock_req) begin
            state_d    = S_RESET_PLL;
            attempts_d = '0;
            relock_inc = run_seen_q || (state_q == S_RUN);
        end

        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end

        relock_count_d = relock_count_q;
        if (relock_inc && (relock_count_q != 8'hFF)) begin
            relock_count_d = relock_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_RESET_PLL;
            cnt_q          <= '0;
            attempts_q     <= '0;
            relock_count_q <= 8'd0;
            run_seen_q     <= 1'b0;
            pll_rst_q      <= 1'b1;
            out_reset_n_q  <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            attempts_q     <= attempts_d;
            relock_count_q <= relock_count_d;
            run_seen_q     <= run_seen_q || (state_q == S_RUN);
            pll_rst_q      <= (state_d == S_RESET_PLL);
            out_reset_n_q  <= (state_d == S_RUN);
            fault_q        <= (state_d == S_FAULT);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign out_reset_n  = out_reset_n_q;
    assign fault        = fault_q;
    assign state        = state_q;
    assign relock_count = relock_count_q;

endmodule
